shift_sequencer: RTL and testbench
==================================

Name: shift_sequencer

Overview:
Multi-cycle controller that decodes the ARM data-processing operand2 field of the instruction register and drives an iterative shift/rotate of Rm (or the rotated imm8) to produce the shifter operand and shifter carry-out.
It sits between the instruction decode/register-file read stage and the ALU.
It handles immediate-amount shifts, register-specified shifts (Rs[7:0]), the 32-bit rotated immediate, and all ARM special cases (LSR/ASR #0 meaning #32, ROR #0 meaning RRX, and amounts of 32 or more).
It uses a start/busy/done handshake.

Parameters:
STEP, 1, maximum bits shifted per SHIFT cycle; legal values 1, 2, 4, 8.

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
start  in  1  request; sampled only in IDLE
abort  in  1  synchronous cancel; returns to IDLE with no done
ir  in  32  instruction register (uses [25], [11:0])
rm_val  in  32  Rm contents
rs_val  in  32  Rs contents (only [7:0] used)
c_in  in  1  current CPSR C flag
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse when result is valid
result  out  32  shifter operand
c_out  out  1  shifter carry-out

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; busy=0, done=0, result=0, c_out=0.
  - Internal counters and registers cleared.
  - Reset mid-operation discards the operation.
- States:
  - IDLE: on start=1, register ir, rm_val, rs_val[7:0], c_in; go to DECODE.
  - DECODE: compute type, amount N and data; go to SHIFT if N>0, otherwise go to DONE.
  - SHIFT: shift by k=min(STEP, remaining); remaining-=k; carry=last bit shifted out; go to DONE when remaining reaches 0.
  - DONE: done=1 for exactly one cycle, then IDLE.
- Latency: done is high in the cycle N_cyc+2 after the accepting edge, where N_cyc=ceil(N/STEP).
- result and c_out are held stable from DONE until the next start is accepted.
- Decode rules (type encoding: 00 LSL, 01 LSR, 10 ASR, 11 ROR):
  - ir[25]=1: data=zero-extended ir[7:0]; ROR by 2*ir[11:8].
    - If the amount is 0: c_out=c_in.
    - Otherwise: c_out=result[31].
  - ir[25]=0, ir[4]=0: type ir[6:5], amt5=ir[11:7].
    - LSL #0: N=0, c_out=c_in.
    - LSR #0 and ASR #0 mean #32.
    - ROR #0 is RRX: N=1, with c_in shifted into bit 31; c_out=rm[0].
  - ir[25]=0, ir[4]=1: n=rs_val[7:0].
    - n=0: N=0, result=rm, c_out=c_in.
    - LSL/LSR: N=min(n,33), which naturally yields 0 with carry=0 beyond 32.
    - ASR: N=min(n,32).
    - ROR: N=n[4:0]; if that is 0 and n≠0, N=32, giving result=rm and c_out=rm[31].
- Shift semantics per step:
  - LSL fills with 0.
  - LSR fills with 0.
  - ASR fills with the sign bit.
  - ROR wraps around.
  - RRX inserts c_in.
- Carry register initialises to c_in in DECODE.
- start while busy: ignored, with no queueing.
- abort: takes priority over all transitions. In any non-IDLE state it goes to IDLE, done is not asserted, and result/c_out keep their previous values.
- start and abort both high in IDLE: abort wins; the request is not accepted.

Optional Feature:
SHIFT_SEQ_STATS_EN:
- Defined: adds output ports op_count[31:0] (incremented on each DONE) and shift_cycles[31:0] (incremented on each SHIFT cycle). Both are cleared by rst_n and wrap at 2^32.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Package shift_pkg:
  - shift-type enum (LSL/LSR/ASR/ROR) plus RRX internal code.
  - state enum (IDLE/DECODE/SHIFT/DONE).
  - IR field position constants: I bit 25, reg-shift bit 4, type [6:5], imm amount [11:7], rot [11:8], imm8 [7:0].
  - constant MAX_LSR_AMT=33.
- Sub-module shift_step: combinational shift by k (0..STEP) of a 32-bit value with carry-in/carry-out for a given type. It is instantiated once in the SHIFT datapath.

Test Plan:
1. ir LSL #4 immediate, rm=0x8000000F, c_in=0, STEP=1 → result=0x000000F0, c_out=0; done in cycle 6 after start; busy high in cycles 1–5.
2. ir ROR #0 immediate (RRX), rm=0x00000001, c_in=1 → result=0x80000000, c_out=1; done in cycle 3.
3. Register LSR with rm=0xFFFFFFFF:
   - rs=0x20 → result=0, c_out=1.
   - rs=0x21 → result=0, c_out=0.
   - rs=0xFF → result=0, c_out=0, completing in 33 SHIFT cycles.
4. Register ROR with rm=0x80000001, c_in=0:
   - rs=0x40 → result=0x80000001, c_out=1.
   - rs=0x00 → result=0x80000001, c_out=0, done in cycle 2.
5. Immediate operand ir[25]=1, imm8=0xFF, rot=4, STEP=4 → result=0xFF000000, c_out=1 after 2 SHIFT cycles. Repeat with STEP=8 → 1 SHIFT cycle, same result.
6. Control cases:
   - start pulsed while busy → ignored.
   - abort in the 3rd SHIFT cycle → IDLE, no done, previous result held.
   - rst_n low mid-SHIFT → all outputs 0 immediately, with no done after release.

Source files
------------

// File: rtl/shift_pkg.sv
// Shared types and constants for the operand2 shift sequencer.
package shift_pkg;

  typedef enum logic [2:0] {
    SH_LSL = 3'd0,
    SH_LSR = 3'd1,
    SH_ASR = 3'd2,
    SH_ROR = 3'd3,
    SH_RRX = 3'd4
  } shift_type_e;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_DECODE = 2'd1;
  localparam logic [1:0] ST_SHIFT  = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

  localparam int unsigned IR_I_BIT   = 25;
  localparam int unsigned IR_REG_BIT = 4;
  localparam int unsigned IR_TYPE_LO = 5;
  localparam int unsigned IR_TYPE_HI = 6;
  localparam int unsigned IR_AMT_LO  = 7;
  localparam int unsigned IR_AMT_HI  = 11;
  localparam int unsigned IR_ROT_LO  = 8;
  localparam int unsigned IR_ROT_HI  = 11;
  localparam int unsigned IR_IMM_LO  = 0;
  localparam int unsigned IR_IMM_HI  = 7;

  localparam int unsigned MAX_LSR_AMT = 33;
  localparam int unsigned MAX_ASR_AMT = 32;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned AMT_W  = 6;
  localparam int unsigned K_W    = 4;

endpackage

// File: rtl/shift_step.sv
// Combinational shift of a 32-bit word by k (0..STEP) single-bit steps with carry.
module shift_step
  import shift_pkg::*;
#(
  parameter int unsigned STEP = 1
) (
  input  logic [DATA_W-1:0] data_i,
  input  logic              carry_i,
  input  shift_type_e       type_i,
  input  logic [K_W-1:0]    k_i,
  output logic [DATA_W-1:0] data_c,
  output logic              carry_c
);

  logic lsb;

  // Chain of one-bit steps; carry always reflects the last bit shifted out.
  always_comb begin
    data_c  = data_i;
    carry_c = carry_i;
    lsb     = 1'b0;
    for (int i = 0; i < int'(STEP); i++) begin
      if (K_W'(i) < k_i) begin
        lsb = data_c[0];
        case (type_i)
          SH_LSL: begin
            carry_c = data_c[DATA_W-1];
            data_c  = {data_c[DATA_W-2:0], 1'b0};
          end
          SH_LSR: begin
            data_c  = {1'b0, data_c[DATA_W-1:1]};
            carry_c = lsb;
          end
          SH_ASR: begin
            data_c  = {data_c[DATA_W-1], data_c[DATA_W-1:1]};
            carry_c = lsb;
          end
          SH_ROR: begin
            data_c  = {lsb, data_c[DATA_W-1:1]};
            carry_c = lsb;
          end
          SH_RRX: begin
            data_c  = {carry_c, data_c[DATA_W-1:1]};
            carry_c = lsb;
          end
          default: begin
            data_c  = data_c;
            carry_c = carry_c;
          end
        endcase
      end
    end
  end

endmodule

// File: rtl/shift_sequencer.sv
// Multi-cycle ARM operand2 shifter: decode, then shift STEP bits per cycle.
// Defining SHIFT_SEQ_STATS_EN adds the op_count/shift_cycles statistics ports.
module shift_sequencer
  import shift_pkg::*;
#(
  parameter int unsigned STEP = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        abort,
  input  logic [31:0] ir,
  input  logic [31:0] rm_val,
  input  logic [31:0] rs_val,
  input  logic        c_in,
  output logic        busy,
  output logic        done,
  output logic [31:0] result,
  output logic        c_out
`ifdef SHIFT_SEQ_STATS_EN
  ,
  output logic [31:0] op_count,
  output logic [31:0] shift_cycles
`endif
);

  logic [1:0]        state_q, state_d;
  logic              busy_q, busy_d, done_q, done_d, c_out_q, c_out_d;
  logic [DATA_W-1:0] result_q, result_d;
  logic              i_q, i_d, cin_q, cin_d;
  logic [11:0]       op2_q, op2_d;
  logic [DATA_W-1:0] rm_q, rm_d;
  logic [7:0]        rs_q, rs_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              carry_q, carry_d;
  logic [AMT_W-1:0]  rem_q, rem_d;
  shift_type_e       type_q, type_d;

  shift_type_e       dec_type;
  logic [AMT_W-1:0]  dec_n;
  logic [DATA_W-1:0] dec_data;
  logic              dec_carry;
  logic [4:0]        amt5;
  logic [K_W-1:0]    k_c;
  logic [DATA_W-1:0] step_data_c;
  logic              step_carry_c;
  logic              unused_ok;

  assign unused_ok = ^{ir[31:26], ir[24:12], rs_val[31:8]};

  // Operand2 decode into shift type, total amount and starting data/carry.
  always_comb begin
    dec_type  = SH_LSL;
    dec_n     = '0;
    dec_data  = rm_q;
    dec_carry = cin_q;
    amt5      = op2_q[IR_AMT_HI:IR_AMT_LO];
    if (i_q) begin
      dec_type = SH_ROR;
      dec_data = DATA_W'(op2_q[IR_IMM_HI:IR_IMM_LO]);
      dec_n    = {1'b0, op2_q[IR_ROT_HI:IR_ROT_LO], 1'b0};
    end else if (!op2_q[IR_REG_BIT]) begin
      case (op2_q[IR_TYPE_HI:IR_TYPE_LO])
        2'b00: begin
          dec_type = SH_LSL;
          dec_n    = AMT_W'(amt5);
        end
        2'b01: begin
          dec_type = SH_LSR;
          dec_n    = (amt5 == 5'd0) ? AMT_W'(32) : AMT_W'(amt5);
        end
        2'b10: begin
          dec_type = SH_ASR;
          dec_n    = (amt5 == 5'd0) ? AMT_W'(32) : AMT_W'(amt5);
        end
        default: begin
          dec_type = (amt5 == 5'd0) ? SH_RRX : SH_ROR;
          dec_n    = (amt5 == 5'd0) ? AMT_W'(1) : AMT_W'(amt5);
        end
      endcase
    end else begin
      case (op2_q[IR_TYPE_HI:IR_TYPE_LO])
        2'b00: begin
          dec_type = SH_LSL;
          dec_n    = (rs_q > 8'(MAX_LSR_AMT)) ? AMT_W'(MAX_LSR_AMT) : AMT_W'(rs_q);
        end
        2'b01: begin
          dec_type = SH_LSR;
          dec_n    = (rs_q > 8'(MAX_LSR_AMT)) ? AMT_W'(MAX_LSR_AMT) : AMT_W'(rs_q);
        end
        2'b10: begin
          dec_type = SH_ASR;
          dec_n    = (rs_q > 8'(MAX_ASR_AMT)) ? AMT_W'(MAX_ASR_AMT) : AMT_W'(rs_q);
        end
        default: begin
          dec_type = SH_ROR;
          dec_n    = (rs_q[4:0] == 5'd0) ? AMT_W'(32) : AMT_W'(rs_q[4:0]);
        end
      endcase
      if (rs_q == 8'd0) dec_n = '0;
    end
  end

  assign k_c = (rem_q < AMT_W'(STEP)) ? K_W'(rem_q) : K_W'(STEP);

  shift_step #(.STEP(STEP)) u_step (
    .data_i  (data_q),
    .carry_i (carry_q),
    .type_i  (type_q),
    .k_i     (k_c),
    .data_c  (step_data_c),
    .carry_c (step_carry_c)
  );

  // Next-state and datapath control; abort overrides every non-IDLE transition.
  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    c_out_d  = c_out_q;
    i_d      = i_q;
    op2_d    = op2_q;
    rm_d     = rm_q;
    rs_d     = rs_q;
    cin_d    = cin_q;
    data_d   = data_q;
    carry_d  = carry_q;
    rem_d    = rem_q;
    type_d   = type_q;
    case (state_q)
      ST_IDLE: begin
        if (start && !abort) begin
          i_d     = ir[IR_I_BIT];
          op2_d   = ir[11:0];
          rm_d    = rm_val;
          rs_d    = rs_val[7:0];
          cin_d   = c_in;
          state_d = ST_DECODE;
        end
      end
      ST_DECODE: begin
        data_d  = dec_data;
        carry_d = dec_carry;
        rem_d   = dec_n;
        type_d  = dec_type;
        if (dec_n == '0) begin
          result_d = dec_data;
          c_out_d  = dec_carry;
          state_d  = ST_DONE;
        end else begin
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        data_d  = step_data_c;
        carry_d = step_carry_c;
        rem_d   = rem_q - AMT_W'(k_c);
        if (rem_d == '0) begin
          result_d = step_data_c;
          c_out_d  = step_carry_c;
          state_d  = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (abort && state_q != ST_IDLE) begin
      state_d  = ST_IDLE;
      result_d = result_q;
      c_out_d  = c_out_q;
    end
    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
      c_out_q  <= 1'b0;
      i_q      <= 1'b0;
      op2_q    <= '0;
      rm_q     <= '0;
      rs_q     <= '0;
      cin_q    <= 1'b0;
      data_q   <= '0;
      carry_q  <= 1'b0;
      rem_q    <= '0;
      type_q   <= SH_LSL;
    end else begin
      state_q  <= state_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      result_q <= result_d;
      c_out_q  <= c_out_d;
      i_q      <= i_d;
      op2_q    <= op2_d;
      rm_q     <= rm_d;
      rs_q     <= rs_d;
      cin_q    <= cin_d;
      data_q   <= data_d;
      carry_q  <= carry_d;
      rem_q    <= rem_d;
      type_q   <= type_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;
  assign c_out  = c_out_q;

`ifdef SHIFT_SEQ_STATS_EN
  logic [31:0] op_count_q, op_count_d, shift_cycles_q, shift_cycles_d;

  always_comb begin
    op_count_d     = op_count_q + 32'(state_q == ST_DONE);
    shift_cycles_d = shift_cycles_q + 32'(state_q == ST_SHIFT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_count_q     <= '0;
      shift_cycles_q <= '0;
    end else begin
      op_count_q     <= op_count_d;
      shift_cycles_q <= shift_cycles_d;
    end
  end

  assign op_count     = op_count_q;
  assign shift_cycles = shift_cycles_q;
`endif

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed self-checking bench for shift_sequencer at STEP = 1, 4 and 8.
module tb_shift_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [31:0] ir = '0;
  logic [31:0] rm_val = '0;
  logic [31:0] rs_val = '0;
  logic        c_in = 1'b0;

  logic        busy1, done1, c1, busy4, done4, c4, busy8, done8, c8;
  logic [31:0] res1, res4, res8;
`ifdef SHIFT_SEQ_STATS_EN
  logic [31:0] opc1, shc1, opc4, shc4, opc8, shc8;
`endif

  int checks = 0;
  int errors = 0;
  int sel = 0;

  logic        s_busy, s_done, s_c;
  logic [31:0] s_res;

  always #5 clk = ~clk;

  always_comb begin
    case (sel)
      1:       begin s_busy = busy4; s_done = done4; s_res = res4; s_c = c4; end
      2:       begin s_busy = busy8; s_done = done8; s_res = res8; s_c = c8; end
      default: begin s_busy = busy1; s_done = done1; s_res = res1; s_c = c1; end
    endcase
  end

  shift_sequencer #(.STEP(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .ir(ir),
    .rm_val(rm_val), .rs_val(rs_val), .c_in(c_in),
    .busy(busy1), .done(done1), .result(res1), .c_out(c1)
`ifdef SHIFT_SEQ_STATS_EN
    , .op_count(opc1), .shift_cycles(shc1)
`endif
  );

  shift_sequencer #(.STEP(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .ir(ir),
    .rm_val(rm_val), .rs_val(rs_val), .c_in(c_in),
    .busy(busy4), .done(done4), .result(res4), .c_out(c4)
`ifdef SHIFT_SEQ_STATS_EN
    , .op_count(opc4), .shift_cycles(shc4)
`endif
  );

  shift_sequencer #(.STEP(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .ir(ir),
    .rm_val(rm_val), .rs_val(rs_val), .c_in(c_in),
    .busy(busy8), .done(done8), .result(res8), .c_out(c8)
`ifdef SHIFT_SEQ_STATS_EN
    , .op_count(opc8), .shift_cycles(shc8)
`endif
  );

  task automatic wait_idle();
    int n = 0;
    while ((busy1 || busy4 || busy8) && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (busy1 || busy4 || busy8) begin
      errors++;
      $display("FAIL wait_idle busy=%b%b%b expected 000", busy1, busy4, busy8);
    end
  endtask

  // Launch one op and follow the selected DUT until done (cycle 1 = after the accepting edge).
  task automatic run_op(input int dsel, input logic [31:0] i_ir, input logic [31:0] i_rm,
                        input logic [31:0] i_rs, input logic i_c,
                        output int dcyc, output int busy_lo);
    wait_idle();
    sel = dsel;
    ir = i_ir; rm_val = i_rm; rs_val = i_rs; c_in = i_c; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    dcyc = -1;
    busy_lo = 0;
    for (int cyc = 1; cyc <= 100; cyc++) begin
      if (s_done) begin
        dcyc = cyc;
        break;
      end
      if (!s_busy) busy_lo++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    checks++;
    if (busy1 !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy1); end
    checks++;
    if (done1 !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", done1); end
    checks++;
    if (res1 !== 32'h0) begin errors++; $display("FAIL reset_result got=%h exp=0", res1); end
    checks++;
    if (c1 !== 1'b0) begin errors++; $display("FAIL reset_c_out got=%b exp=0", c1); end
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_imm_shift();
    int d, bl;
    run_op(0, 32'h0000_0200, 32'h8000_000F, 32'h0, 1'b0, d, bl);
    checks++;
    if (s_res !== 32'h0000_00F0) begin errors++; $display("FAIL lsl4_result got=%h exp=000000f0", s_res); end
    checks++;
    if (s_c !== 1'b0) begin errors++; $display("FAIL lsl4_c_out got=%b exp=0", s_c); end
    checks++;
    if (d !== 6) begin errors++; $display("FAIL lsl4_latency got=%0d exp=6", d); end
    checks++;
    if (bl !== 0) begin errors++; $display("FAIL lsl4_busy_low_cycles got=%0d exp=0", bl); end
    @(posedge clk); #1;
    checks++;
    if ({busy1, done1} !== 2'b00) begin errors++; $display("FAIL lsl4_after_done busy,done got=%b exp=00", {busy1, done1}); end

    run_op(0, 32'h0000_0000, 32'h1234_5678, 32'h0, 1'b1, d, bl);
    checks++;
    if ({s_res, s_c} !== {32'h1234_5678, 1'b1}) begin errors++; $display("FAIL lsl0 got=%h/%b exp=12345678/1", s_res, s_c); end
    checks++;
    if (d !== 2) begin errors++; $display("FAIL lsl0_latency got=%0d exp=2", d); end

    run_op(0, 32'h0000_0020, 32'h8000_0000, 32'h0, 1'b0, d, bl);
    checks++;
    if ({s_res, s_c} !== {32'h0, 1'b1}) begin errors++; $display("FAIL lsr0_is_32 got=%h/%b exp=00000000/1", s_res, s_c); end
    checks++;
    if (d !== 34) begin errors++; $display("FAIL lsr0_latency got=%0d exp=34", d); end

    run_op(0, 32'h0000_0040, 32'h8000_0000, 32'h0, 1'b0, d, bl);
    checks++;
    if ({s_res, s_c} !== {32'hFFFF_FFFF, 1'b1}) begin errors++; $display("FAIL asr0_is_32 got=%h/%b exp=ffffffff/1", s_res, s_c); end
  endtask

  task automatic test_rrx();
    int d, bl;
    run_op(0, 32'h0000_0060, 32'h0000_0001, 32'h0, 1'b1, d, bl);
    checks++;
    if ({s_res, s_c} !== {32'h8000_0000, 1'b1}) begin errors++; $display("FAIL rrx got=%h/%b exp=80000000/1", s_res, s_c); end
    checks++;
    if (d !== 3) begin errors++; $display("FAIL rrx_latency got=%0d exp=3", d); end
  endtask

  task automatic test_reg_shift();
    int d, bl;
    run_op(0, 32'h0000_0030, 32'hFFFF_FFFF, 32'h20, 1'b0, d, bl);
    checks++;
    if ({s_res, s_c} !== {32'h0, 1'b1}) begin errors++; $display("FAIL reg_lsr32 got=%h/%b exp=00000000/1", s_res, s_c); end
    run_op(0, 32'h0000_0030, 32'hFFFF_FFFF, 32'h21, 1'b1, d, bl);
    checks++;
    if ({s_res, s_c} !== {32'h0, 1'b0}) begin errors++; $display("FAIL reg_lsr33 got=%h/%b exp=00000000/0", s_res, s_c); end
    run_op(0, 32'h0000_0030, 32'hFFFF_FFFF, 32'hFF, 1'b1, d, bl);
    checks++;
    if ({s_res, s_c} !== {32'h0, 1'b0}) begin errors++; $display("FAIL reg_lsr255 got=%h/%b exp=00000000/0", s_res, s_c); end
    checks++;
    if (d !== 35) begin errors++; $display("FAIL reg_lsr255_latency got=%0d exp=35", d); end

    run_op(0, 32'h0000_0070, 32'h8000_0001, 32'h40, 1'b0, d, bl);
    checks++;
    if ({s_res, s_c} !== {32'h8000_0001, 1'b1}) begin errors++; $display("FAIL reg_ror64 got=%h/%b exp=80000001/1", s_res, s_c); end
    run_op(0, 32'h0000_0070, 32'h8000_0001, 32'h00, 1'b0, d, bl);
    checks++;
    if ({s_res, s_c} !== {32'h8000_0001, 1'b0}) begin errors++; $display("FAIL reg_ror0 got=%h/%b exp=80000001/0", s_res, s_c); end
    checks++;
    if (d !== 2) begin errors++; $display("FAIL reg_ror0_latency got=%0d exp=2", d); end

    run_op(0, 32'h0000_0050, 32'h8000_0000, 32'h50, 1'b0, d, bl);
    checks++;
    if ({s_res, s_c} !== {32'hFFFF_FFFF, 1'b1}) begin errors++; $display("FAIL reg_asr80 got=%h/%b exp=ffffffff/1", s_res, s_c); end
  endtask

  task automatic test_rot_imm();
    int d, bl;
    run_op(1, 32'h0200_04FF, 32'h0, 32'h0, 1'b0, d, bl);
    checks++;
    if ({s_res, s_c} !== {32'hFF00_0000, 1'b1}) begin errors++; $display("FAIL imm_step4 got=%h/%b exp=ff000000/1", s_res, s_c); end
    checks++;
    if (d !== 4) begin errors++; $display("FAIL imm_step4_latency got=%0d exp=4", d); end
    run_op(2, 32'h0200_04FF, 32'h0, 32'h0, 1'b0, d, bl);
    checks++;
    if ({s_res, s_c} !== {32'hFF00_0000, 1'b1}) begin errors++; $display("FAIL imm_step8 got=%h/%b exp=ff000000/1", s_res, s_c); end
    checks++;
    if (d !== 3) begin errors++; $display("FAIL imm_step8_latency got=%0d exp=3", d); end
    run_op(0, 32'h0200_005A, 32'h0, 32'h0, 1'b1, d, bl);
    checks++;
    if ({s_res, s_c} !== {32'h0000_005A, 1'b1}) begin errors++; $display("FAIL imm_rot0 got=%h/%b exp=0000005a/1", s_res, s_c); end
  endtask

  task automatic test_start_while_busy();
    int d = -1;
    int extra = 0;
    wait_idle();
    sel = 0;
    ir = 32'h0000_0200; rm_val = 32'h8000_000F; rs_val = 32'h0; c_in = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    ir = 32'h0000_0060; rm_val = 32'h0000_0001; c_in = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int cyc = 3; cyc <= 100; cyc++) begin
      if (done1) begin
        d = cyc;
        break;
      end
      @(posedge clk); #1;
    end
    checks++;
    if ({res1, c1} !== {32'h0000_00F0, 1'b0}) begin errors++; $display("FAIL busy_start_result got=%h/%b exp=000000f0/0", res1, c1); end
    checks++;
    if (d !== 6) begin errors++; $display("FAIL busy_start_latency got=%0d exp=6", d); end
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (busy1 || done1) extra++;
    end
    checks++;
    if (extra !== 0) begin errors++; $display("FAIL busy_start_queued got=%0d active cycles exp=0", extra); end
  endtask

  task automatic test_abort();
    int d, bl;
    int seen = 0;
    run_op(0, 32'h0000_0200, 32'h8000_000F, 32'h0, 1'b0, d, bl);
    wait_idle();
    ir = 32'h0000_0030; rm_val = 32'hFFFF_FFFF; rs_val = 32'h20; c_in = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    checks++;
    if (busy1 !== 1'b0) begin errors++; $display("FAIL abort_busy got=%b exp=0", busy1); end
    checks++;
    if ({res1, c1} !== {32'h0000_00F0, 1'b0}) begin errors++; $display("FAIL abort_hold got=%h/%b exp=000000f0/0", res1, c1); end
    for (int i = 0; i < 40; i++) begin
      if (done1) seen++;
      @(posedge clk); #1;
    end
    checks++;
    if (seen !== 0) begin errors++; $display("FAIL abort_no_done got=%0d done cycles exp=0", seen); end

    start = 1'b1; abort = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
    checks++;
    if (busy1 !== 1'b0) begin errors++; $display("FAIL abort_start_idle busy got=%b exp=0", busy1); end
  endtask

  task automatic test_reset_mid_shift();
    int seen = 0;
    wait_idle();
    ir = 32'h0000_0030; rm_val = 32'hFFFF_FFFF; rs_val = 32'h20; c_in = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({busy1, done1, c1} !== 3'b000) begin errors++; $display("FAIL rst_mid busy,done,c got=%b exp=000", {busy1, done1, c1}); end
    checks++;
    if (res1 !== 32'h0) begin errors++; $display("FAIL rst_mid_result got=%h exp=00000000", res1); end
    #2;
    rst_n = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (done1 || busy1) seen++;
    end
    checks++;
    if (seen !== 0) begin errors++; $display("FAIL rst_mid_no_done got=%0d active cycles exp=0", seen); end
    checks++;
    if (res1 !== 32'h0) begin errors++; $display("FAIL rst_mid_result_after got=%h exp=00000000", res1); end
  endtask

  initial begin
    #2;
    test_reset();
    test_imm_shift();
    test_rrx();
    test_reg_shift();
    test_rot_imm();
    test_start_while_busy();
    test_abort();
    test_reset_mid_shift();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
